bitrev_pair_feeder: RTL
=======================

BITREV_PAIR_FEEDER -- requirements
Module: bitrev_pair_feeder

Interface
REQ-001 Parameter n, default 32, total fixed-point word width of each real/imag component.
REQ-002 Parameter d, default 16, fractional bits; legal range 0 <= d < n-1.
REQ-003 Parameter logn, default 3, log2 of frame length N = 2^logn; legal range logn >= 1.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 recv_val  input  1  upstream sample valid.
REQ-007 recv_rdy  output  1  block accepts a sample this cycle.
REQ-008 recv_r, recv_c  input  n each  real/imag of incoming sample, natural time order.
REQ-009 send_val  output  1  butterfly operand set valid.
REQ-010 send_rdy  input  1  downstream butterfly accepts operand set.
REQ-011 ar, ac, br, bc  output  n each  operands a and b (real/imag).
REQ-012 wr, wc  output  n each  twiddle for first radix-2 DIT stage.

Function
REQ-013 Two states: FILL and DRAIN; single internal buffer of N complex samples; 2-state FSM plus counters cnt (logn bits) and pair index p (logn-1 bits, zero-width/constant 0 when logn=1).
REQ-014 FILL: recv_rdy=1, send_val=0; on recv_val&recv_rdy, write sample to buffer[cnt], cnt <= cnt+1.
REQ-015 FILL->DRAIN on the handshake where cnt==N-1; cnt <= 0, p <= 0; send_val=1 on the next cycle (1-cycle latency from last accepted sample).
REQ-016 DRAIN: recv_rdy=0, send_val=1; recv_val ignored, buffer not written.
REQ-017 DRAIN outputs combinational from buffer: a = buffer[bitrev(2p)], b = buffer[bitrev(2p+1)], bitrev over logn bits.
REQ-018 On send_val&send_rdy in DRAIN, p <= p+1; outputs change only after a handshake (stable under backpressure).
REQ-019 DRAIN->FILL on the handshake where p==N/2-1; recv_rdy=1 on the next cycle; no overlap of fill and drain.
REQ-020 wr = 2^d (fixed-point 1.0), wc = 0, constant whenever send_val=1.
REQ-021 ar, ac, br, bc, wr, wc = 0 whenever send_val=0.
REQ-022 Sample data passed bit-exact; no arithmetic, no width change.
REQ-023 Throughput: N cycles to fill plus N/2 cycles to drain per frame at full handshake rate.
REQ-024 recv_val gaps in FILL hold cnt; send_rdy low in DRAIN holds p.

Reset
REQ-025 While reset=1: recv_rdy=0, send_val=0, all data outputs 0, handshakes ignored.
REQ-026 Cycle after reset deasserts: state FILL, cnt=0, p=0, recv_rdy=1, send_val=0.
REQ-027 Buffer contents not reset; a reset in any state (incl. mid-fill or mid-drain) discards the partial frame.

Verification (logn=3, n=32, d=16)
REQ-028 Basic: push samples k=0..7 as r=k, c=-k back-to-back, send_rdy=1 -> send_val rises 1 cycle after 8th accept; pairs (ar,br) = (0,4),(2,6),(1,5),(3,7), ac=-ar, bc=-br, wr=0x00010000, wc=0; recv_rdy=1 cycle after 4th handshake.
REQ-029 Backpressure: hold send_rdy=0 for 5 cycles on pair 1 -> ar=2, br=6 stable, send_val=1 throughout; resume -> remaining pairs in order.
REQ-030 Input gaps: recv_val toggled 1,0,1,0 during fill -> exactly 8 accepted samples, same pair order as REQ-028.
REQ-031 Ignore in DRAIN: recv_val=1 with r=99 throughout drain -> recv_rdy=0, no output pair contains 99, next frame unaffected.
REQ-032 Reset mid-drain after pair 1 -> next cycle recv_rdy=1, send_val=0, outputs 0; fresh frame k=10..17 yields (10,14),(12,16),(11,15),(13,17).
REQ-033 Back-to-back frames: two frames streamed with recv_val=1, send_rdy=1 continuously -> 24 cycles total, second frame pairs correct, no sample lost or duplicated.

Source files
------------

// File: rtl/bitrev_pair_feeder.sv
// rtl/bitrev_pair_feeder.sv - frame buffer feeding bit-reversed operand pairs to a radix-2 DIT butterfly
//
// Collects N = 2^logn complex samples in natural order (FILL), then presents them
// two at a time in bit-reversed order as butterfly operands a/b with a unity
// twiddle (DRAIN). Fill and drain never overlap.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   recv_val/recv_rdy     upstream sample handshake, recv_r/recv_c sample data
//   send_val/send_rdy     downstream operand-set handshake
//   ar, ac, br, bc        operands a and b (real/imag), zero when send_val=0
//   wr, wc                twiddle (1.0 + 0j), zero when send_val=0

module bitrev_pair_feeder #(
    parameter int n    = 32,
    parameter int d    = 16,
    parameter int logn = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         recv_val,
    output logic         recv_rdy,
    input  logic [n-1:0] recv_r,
    input  logic [n-1:0] recv_c,
    output logic         send_val,
    input  logic         send_rdy,
    output logic [n-1:0] ar,
    output logic [n-1:0] ac,
    output logic [n-1:0] br,
    output logic [n-1:0] bc,
    output logic [n-1:0] wr,
    output logic [n-1:0] wc
);

    localparam int N  = 1 << logn;
    localparam int LW = logn;
    // Pair index needs logn-1 bits; for logn=1 keep one bit that stays at 0.
    localparam int PW = (logn > 1) ? logn - 1 : 1;

    localparam logic [LW-1:0] CNT_LAST = LW'(N - 1);
    localparam logic [PW-1:0] P_LAST   = PW'(N / 2 - 1);
    localparam logic [n-1:0]  W_ONE    = {{(n-1){1'b0}}, 1'b1} << d;

    typedef enum logic {FILL, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] p_q, p_d;

    logic [n-1:0]  buf_r_q [N];
    logic [n-1:0]  buf_c_q [N];

    logic          recv_fire;
    logic          send_fire;
    logic [LW-1:0] even_idx;
    logic [LW-1:0] odd_idx;
    logic [LW-1:0] a_idx;
    logic [LW-1:0] b_idx;

    function automatic logic [LW-1:0] bitrev(input logic [LW-1:0] x);
        logic [LW-1:0] r;
        for (int i = 0; i < LW; i++) begin
            r[i] = x[LW-1-i];
        end
        return r;
    endfunction

    always_comb begin
        recv_rdy  = !reset && (state_q == FILL);
        send_val  = !reset && (state_q == DRAIN);
        recv_fire = recv_val && recv_rdy;
        send_fire = send_val && send_rdy;

        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;

        case (state_q)
            FILL: begin
                if (recv_fire) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = DRAIN;
                        cnt_d   = '0;
                        p_d     = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (send_fire) begin
                    if (p_q == P_LAST) begin
                        state_d = FILL;
                        p_d     = '0;
                    end else begin
                        p_d = p_q + 1'b1;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Operand indices: a = bitrev(2p), b = bitrev(2p+1).
    always_comb begin
        even_idx = LW'({p_q, 1'b0});
        odd_idx  = even_idx | LW'(1);
        a_idx    = bitrev(even_idx);
        b_idx    = bitrev(odd_idx);
    end

    always_comb begin
        ar = '0;
        ac = '0;
        br = '0;
        bc = '0;
        wr = '0;
        wc = '0;
        if (send_val) begin
            ar = buf_r_q[a_idx];
            ac = buf_c_q[a_idx];
            br = buf_r_q[b_idx];
            bc = buf_c_q[b_idx];
            wr = W_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FILL;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    // Sample buffer is deliberately not reset; a reset simply restarts the fill.
    always_ff @(posedge clk) begin
        if (recv_fire) begin
            buf_r_q[cnt_q] <= recv_r;
            buf_c_q[cnt_q] <= recv_c;
        end
    end

endmodule
